// File: rtl/usb_pkt_encoder.sv
// Packet serializer: SYNC, PID, ~PID, payload and CRC5/CRC16, one bit per downstream handshake.
// Output handshake: a bit transfers on a clock edge where bitOutAvail && readyOut; bitOut/lastBit hold otherwise.
module usb_pkt_encoder #(
  parameter int TOKEN_BITS = 11,
  parameter int DATA_BITS  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pktInAvail,
  input  logic [3:0]           pid,
  input  logic [DATA_BITS-1:0] payload,
  output logic                 readyIn,
  output logic                 bitOut,
  output logic                 bitOutAvail,
  input  logic                 readyOut,
  output logic                 lastBit,
  output logic                 done,
  output logic                 err,
  output logic [2:0]           dbg_state
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_SYNC    = 3'd1;
  localparam logic [2:0] S_PID     = 3'd2;
  localparam logic [2:0] S_PAYLOAD = 3'd3;
  localparam logic [2:0] S_CRC     = 3'd4;

  logic [2:0]           state;
  logic [6:0]           cnt;
  logic [3:0]           pid_q;
  logic                 is_data;
  logic                 is_hs;
  logic [DATA_BITS-1:0] shreg;
  logic [4:0]           crc5;
  logic [15:0]          crc16;
  logic                 done_q;
  logic                 err_q;

  logic       fire;
  logic       bit_c;
  logic       last_c;
  logic       seg_end;
  logic [7:0] pid_byte;
  logic       in_token;
  logic       in_data;
  logic       in_hs;

  assign in_token = (pid[3:1] == 3'b100);
  assign in_data  = (pid == 4'b1100);
  assign in_hs    = (pid[3:1] == 3'b010);

  assign pid_byte    = {pid_q, ~pid_q};
  assign bitOutAvail = (state != S_IDLE);
  assign readyIn     = (state == S_IDLE);
  assign fire        = bitOutAvail && readyOut;
  assign bitOut      = bit_c;
  assign lastBit     = last_c;
  assign done        = done_q;
  assign err         = err_q;
  assign dbg_state   = state;

  always_comb begin
    bit_c   = 1'b0;
    last_c  = 1'b0;
    seg_end = 1'b0;
    case (state)
      S_SYNC: begin
        bit_c   = (cnt == 7'd7);
        seg_end = (cnt == 7'd7);
      end
      S_PID: begin
        bit_c   = pid_byte[~cnt[2:0]];
        seg_end = (cnt == 7'd7);
        last_c  = is_hs && seg_end;
      end
      S_PAYLOAD: begin
        bit_c   = shreg[DATA_BITS-1];
        seg_end = is_data ? (cnt == 7'(DATA_BITS - 1)) : (cnt == 7'(TOKEN_BITS - 1));
      end
      S_CRC: begin
        // The CRC field is the complemented remainder, sent MSB first.
        bit_c   = is_data ? ~crc16[15] : ~crc5[4];
        seg_end = is_data ? (cnt == 7'd15) : (cnt == 7'd4);
        last_c  = seg_end;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      pid_q   <= '0;
      is_data <= 1'b0;
      is_hs   <= 1'b0;
      shreg   <= '0;
      crc5    <= '0;
      crc16   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (state == S_IDLE) begin
        if (pktInAvail) begin
          if (in_token || in_data || in_hs) begin
            state   <= S_SYNC;
            cnt     <= '0;
            pid_q   <= pid;
            is_data <= in_data;
            is_hs   <= in_hs;
            crc5    <= 5'h1F;
            crc16   <= 16'hFFFF;
            // Left-align the token field so both packet types shift out of the MSB.
            shreg   <= in_data ? payload
                               : {payload[TOKEN_BITS-1:0], {(DATA_BITS-TOKEN_BITS){1'b0}}};
          end else begin
            err_q <= 1'b1;
          end
        end
      end else if (fire) begin
        cnt <= seg_end ? 7'd0 : cnt + 7'd1;
        if (state == S_PAYLOAD) begin
          shreg <= shreg << 1;
          crc5  <= {crc5[3:0], 1'b0} ^ ((crc5[4] ^ bit_c) ? 5'h05 : 5'h00);
          crc16 <= {crc16[14:0], 1'b0} ^ ((crc16[15] ^ bit_c) ? 16'h8005 : 16'h0000);
        end
        if (state == S_CRC) begin
          crc5  <= {crc5[3:0], 1'b0};
          crc16 <= {crc16[14:0], 1'b0};
        end
        if (last_c) done_q <= 1'b1;
        if (seg_end) begin
          case (state)
            S_SYNC:    state <= S_PID;
            S_PID:     state <= is_hs ? S_IDLE : S_PAYLOAD;
            S_PAYLOAD: state <= S_CRC;
            default:   state <= S_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_usb_pkt_encoder.sv
// Bench for usb_pkt_encoder: random packets and stalls checked bit-by-bit against a queue model,
// with receiver-side CRC residue checks and literal wire patterns.
module tb_usb_pkt_encoder;

  typedef logic bitq_t[$];

  logic        clk = 1'b0;
  logic        rst;
  logic        pktInAvail;
  logic [3:0]  pid;
  logic [63:0] payload;
  logic        readyIn;
  logic        bitOut;
  logic        bitOutAvail;
  logic        readyOut;
  logic        lastBit;
  logic        done;
  logic        err;
  logic [2:0]  dbg_state;

  usb_pkt_encoder #(.TOKEN_BITS(11), .DATA_BITS(64)) dut (
    .clk(clk), .rst(rst), .pktInAvail(pktInAvail), .pid(pid), .payload(payload),
    .readyIn(readyIn), .bitOut(bitOut), .bitOutAvail(bitOutAvail), .readyOut(readyOut),
    .lastBit(lastBit), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [0:0] exp_q[$];
  bitq_t      got_q;
  bitq_t      last_pkt;
  bit         done_due   = 1'b0;
  bit         err_due    = 1'b0;
  bit         stall_en   = 1'b0;
  bit         prev_stall = 1'b0;
  logic       prev_bit;
  logic       prev_last;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: serial CRC remainder from all-ones init, for width 5 or 16.
  function automatic logic [15:0] crc_rem(input bitq_t bits, input int n);
    logic [15:0] r, mask, poly;
    logic        fb;
    mask = (n == 5) ? 16'h001F : 16'hFFFF;
    poly = (n == 5) ? 16'h0005 : 16'h8005;
    r    = mask;
    foreach (bits[i]) begin
      fb = r[n-1] ^ bits[i];
      r  = (r << 1) & mask;
      if (fb) r = r ^ poly;
    end
    return r;
  endfunction

  function automatic bit pid_valid(input logic [3:0] p);
    return (p[3:1] == 3'b100) || (p == 4'b1100) || (p[3:1] == 3'b010);
  endfunction

  function automatic bitq_t model_bits(input logic [3:0] p, input logic [63:0] pl);
    bitq_t q, pq;
    logic [15:0] c;
    int nb, nc;
    q = {};
    pq = {};
    for (int i = 0; i < 7; i++) q.push_back(1'b0);
    q.push_back(1'b1);
    for (int i = 3; i >= 0; i--) q.push_back(p[i]);
    for (int i = 3; i >= 0; i--) q.push_back(~p[i]);
    nb = 0;
    nc = 0;
    if (p[3:1] == 3'b100) begin nb = 11; nc = 5; end
    if (p == 4'b1100)     begin nb = 64; nc = 16; end
    for (int i = nb - 1; i >= 0; i--) pq.push_back(pl[i]);
    if (nc != 0) begin
      c = ~crc_rem(pq, nc);
      foreach (pq[i]) q.push_back(pq[i]);
      for (int i = nc - 1; i >= 0; i--) q.push_back(c[i]);
    end
    return q;
  endfunction

  // downstream readiness
  initial begin
    readyOut = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      readyOut = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // compare process: every cycle against the expected bit queue
  initial begin
    forever begin
      @(negedge clk);
      chk("done", done, done_due);
      if (done_due) chk("readyIn_at_done", readyIn, 1);
      done_due = 1'b0;
      chk("err", err, err_due);
      if (err_due) begin
        chk("readyIn_at_err", readyIn, 1);
        chk("avail_at_err", bitOutAvail, 0);
      end
      err_due = 1'b0;
      if (exp_q.size() == 0) begin
        chk("idle_avail", bitOutAvail, 0);
      end else begin
        chk("avail", bitOutAvail, 1);
        if (prev_stall) begin
          chk("hold_bit", bitOut, prev_bit);
          chk("hold_last", lastBit, prev_last);
        end
        chk("bit", bitOut, exp_q[0]);
        chk("last", lastBit, exp_q.size() == 1);
        prev_stall = bitOutAvail && !readyOut;
        prev_bit   = bitOut;
        prev_last  = lastBit;
        if (bitOutAvail && readyOut) begin
          got_q.push_back(bitOut);
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            done_due   = 1'b1;
            last_pkt   = got_q;
            got_q      = {};
            prev_stall = 1'b0;
          end
        end
      end
    end
  end

  // driver tasks (called just after a rising edge)
  task automatic send_pkt(input logic [3:0] p, input logic [63:0] pl, input bit keep,
                          output int cycles);
    bit acc, accepted;
    bitq_t m;
    pid        = p;
    payload    = pl;
    pktInAvail = 1'b1;
    accepted   = 1'b0;
    cycles     = 0;
    for (int c = 0; c < 400 && !accepted; c++) begin
      @(negedge clk);
      acc = readyIn;
      @(posedge clk);
      #1;
      cycles = c + 1;
      if (acc) accepted = 1'b1;
    end
    chk("accept_timeout", accepted, 1);
    if (pid_valid(p)) begin
      m = model_bits(p, pl);
      foreach (m[i]) exp_q.push_back(m[i]);
    end else begin
      err_due = 1'b1;
    end
    if (!keep) begin
      pktInAvail = 1'b0;
      pid        = 4'($urandom);
      payload    = {$urandom, $urandom};
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !done_due && !err_due && readyIn) ok = 1'b1;
    end
    chk("idle_timeout", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    pktInAvail = 1'b0;
    @(posedge clk);
    #1;
    rst        = 1'b0;
    exp_q      = {};
    got_q      = {};
    done_due   = 1'b0;
    err_due    = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    chk("rst_readyIn", readyIn, 1);
    chk("rst_bitOut", bitOut, 0);
    chk("rst_avail", bitOutAvail, 0);
    chk("rst_lastBit", lastBit, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_residue(input logic [3:0] p);
    bitq_t sub;
    if (p[3:1] == 3'b100) begin
      chk("token_len", last_pkt.size(), 32);
      sub = last_pkt[16:$];
      chk("crc5_residue", crc_rem(sub, 5), 16'h000C);
    end else if (p == 4'b1100) begin
      chk("data_len", last_pkt.size(), 96);
      sub = last_pkt[16:$];
      chk("crc16_residue", crc_rem(sub, 16), 16'h800D);
    end else begin
      chk("hs_len", last_pkt.size(), 16);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    int diffs;
    logic [15:0] v;
    logic [3:0] p;
    logic [63:0] pl;
    bitq_t ref_pkt;

    rst        = 1'b1;
    pktInAvail = 1'b0;
    pid        = 4'h0;
    payload    = '0;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // handshake literal pattern
    send_pkt(4'b0100, 64'h0, 1'b0, cyc);
    wait_idle();
    check_residue(4'b0100);
    v = '0;
    foreach (last_pkt[i]) v = {v[14:0], last_pkt[i]};
    chk("hs_bits", v, 16'b0000000101001011);

    // token, zero address/endpoint
    send_pkt(4'b1000, 64'h0, 1'b0, cyc);
    wait_idle();
    check_residue(4'b1000);

    // data literal payload
    send_pkt(4'b1100, 64'hDEADBEEF_01234567, 1'b0, cyc);
    wait_idle();
    check_residue(4'b1100);
    ref_pkt = last_pkt;

    // same data packet with random downstream stalls
    stall_en = 1'b1;
    send_pkt(4'b1100, 64'hDEADBEEF_01234567, 1'b0, cyc);
    wait_idle();
    stall_en = 1'b0;
    diffs = 0;
    foreach (ref_pkt[i]) if (i >= last_pkt.size() || last_pkt[i] !== ref_pkt[i]) diffs++;
    chk("stall_seq_diff", diffs, 0);

    // unsupported PID
    send_pkt(4'b0000, 64'h0, 1'b0, cyc);
    wait_idle();
    chk("err_readyIn_after", readyIn, 1);

    // back-to-back packets with pktInAvail held high
    send_pkt(4'b0101, 64'h0, 1'b1, cyc);
    send_pkt(4'b1001, 64'hFFFF_FFFF_FFFF_F123, 1'b1, cyc);
    chk("b2b_gap_hs", cyc, 17);
    send_pkt(4'b1100, {$urandom, $urandom}, 1'b0, cyc);
    chk("b2b_gap_token", cyc, 33);
    wait_idle();
    check_residue(4'b1100);

    // reset in the middle of a data packet
    send_pkt(4'b1100, {$urandom, $urandom}, 1'b0, cyc);
    begin
      bit reached;
      reached = 1'b0;
      for (int c = 0; c < 500 && !reached; c++) begin
        @(posedge clk);
        #1;
        if (got_q.size() >= 40) reached = 1'b1;
      end
      chk("reach_bit40", reached, 1);
    end
    do_reset();
    send_pkt(4'b1000, {$urandom, $urandom}, 1'b0, cyc);
    wait_idle();
    check_residue(4'b1000);
    send_pkt(4'b1100, {$urandom, $urandom}, 1'b0, cyc);
    wait_idle();
    check_residue(4'b1100);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0:       p = 4'b1100;
        1:       p = {3'b100, 1'($urandom)};
        2:       p = {3'b010, 1'($urandom)};
        default: p = 4'($urandom);
      endcase
      pl       = {$urandom, $urandom};
      stall_en = ($urandom_range(0, 1) == 1);
      send_pkt(p, pl, 1'b0, cyc);
      wait_idle();
      if (pid_valid(p)) check_residue(p);
    end
    stall_en = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
